// File: rtl/deck_shuffler.sv
// Builds the ordered 52-card deck, Fisher-Yates shuffles it in place with a seeded
// Galois LFSR, then streams it over valid/ready. Optional checker: `SHUFFLE_CHECK_EN.
//
// state  | meaning
// IDLE   | waiting for start, seed_load honoured
// FILL   | writing ordered deck, one card per cycle
// DRAW   | drawing random j for current i (rejection sampling)
// SWAP   | swapping mem[i] and mem[j]
// STREAM | presenting mem[idx] on card_out
// DONE   | stream complete, seed_load/start honoured
module deck_shuffler #(
  parameter int          MAX_REJECT = 8,
  parameter logic [15:0] DEF_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  input  logic        seed_load,
  input  logic        start,
  output logic [6:0]  card_out,
  output logic [5:0]  card_idx,
  output logic        card_valid,
  input  logic        card_ready,
  output logic        busy,
  output logic        done,
  output logic        dup_err
);

  localparam int RW = $clog2(MAX_REJECT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_DRAW, S_SWAP, S_STREAM, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [5:0]      i_q, i_d;
  logic [5:0]      j_q, j_d;
  logic [RW-1:0]   rej_q, rej_d;
  logic [6:0]      mem_q [52];
  logic [6:0]      mem_d [52];

  logic [15:0]     lfsr_step;
  logic [5:0]      r;
  logic [RW-1:0]   rej_inc;
  logic            accept_cmd;

  assign lfsr_step  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign r          = lfsr_q[5:0];
  assign rej_inc    = rej_q + RW'(1);
  assign accept_cmd = (state_q == S_IDLE) || (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    i_d     = i_q;
    j_d     = j_q;
    rej_d   = rej_q;
    mem_d   = mem_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (seed_load) lfsr_d = (seed == 16'h0000) ? DEF_SEED : seed;
        if (start) begin
          state_d = S_FILL;
          cnt_d   = 6'd0;
        end
      end
      S_FILL: begin
        mem_d[cnt_q] = {cnt_q[5:2] + 4'd1, cnt_q[1:0], 1'b0};
        if (cnt_q == 6'd51) begin
          state_d = S_DRAW;
          i_d     = 6'd51;
          rej_d   = '0;
          cnt_d   = 6'd0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_DRAW: begin
        lfsr_d = lfsr_step;
        if (r <= i_q) begin
          j_d     = r;
          state_d = S_SWAP;
        end else if (rej_inc == RW'(MAX_REJECT)) begin
          // bound shuffle time: give up and leave card i in place
          j_d     = i_q;
          state_d = S_SWAP;
        end else begin
          rej_d = rej_inc;
        end
      end
      S_SWAP: begin
        mem_d[i_q] = mem_q[j_q];
        mem_d[j_q] = mem_q[i_q];
        rej_d      = '0;
        if (i_q == 6'd1) begin
          state_d = S_STREAM;
          cnt_d   = 6'd0;
        end else begin
          i_d     = i_q - 6'd1;
          state_d = S_DRAW;
        end
      end
      S_STREAM: begin
        if (card_ready) begin
          if (cnt_q == 6'd51) begin
            state_d = S_DONE;
            cnt_d   = 6'd0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= DEF_SEED;
      cnt_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      rej_q   <= '0;
      for (int n = 0; n < 52; n++) mem_q[n] <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      i_q     <= i_d;
      j_q     <= j_d;
      rej_q   <= rej_d;
      mem_q   <= mem_d;
    end
  end

  assign card_valid = (state_q == S_STREAM);
  assign card_out   = card_valid ? mem_q[cnt_q] : 7'd0;
  assign card_idx   = card_valid ? cnt_q : 6'd0;
  assign busy       = (state_q == S_FILL) || (state_q == S_DRAW) ||
                      (state_q == S_SWAP) || (state_q == S_STREAM);
  assign done       = (state_q == S_DONE);

`ifdef SHUFFLE_CHECK_EN
  logic [51:0] seen_q, seen_d;
  logic        dup_q, dup_d;
  logic [3:0]  rank;
  logic [5:0]  bit_n;

  assign rank  = card_out[6:3];
  assign bit_n = {rank - 4'd1, card_out[2:1]};

  always_comb begin
    seen_d = seen_q;
    dup_d  = dup_q;
    if (accept_cmd && start) begin
      seen_d = '0;
      dup_d  = 1'b0;
    end else if (card_valid && card_ready) begin
      if (rank == 4'd0 || rank > 4'd13) begin
        dup_d = 1'b1;
      end else begin
        if (seen_q[bit_n]) dup_d = 1'b1;
        seen_d[bit_n] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_q <= '0;
      dup_q  <= 1'b0;
    end else begin
      seen_q <= seen_d;
      dup_q  <= dup_d;
    end
  end

  assign dup_err = dup_q;
`else
  logic unused_accept;
  assign unused_accept = accept_cmd;
  assign dup_err       = 1'b0;
`endif

endmodule

// File: tb/tb_deck_shuffler.sv
// Self-checking bench for deck_shuffler: a plain Fisher-Yates model with the same
// LFSR and rejection bound predicts every streamed card and the start-to-valid latency.
module tb_deck_shuffler;

  localparam int MAX_REJ = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] seed = 16'h0000;
  logic        seed_load = 1'b0;
  logic        start = 1'b0;
  logic        card_ready = 1'b0;
  logic [6:0]  card_out;
  logic [5:0]  card_idx;
  logic        card_valid, busy, done, dup_err;

  int errors = 0;
  int checks = 0;

  logic [6:0] exp_deck [52];
  int         draws_at [52];
  int         exp_draws;
  logic [6:0] got [52];
  int         got_n;

  deck_shuffler dut (
    .clk(clk), .rst(rst), .seed(seed), .seed_load(seed_load), .start(start),
    .card_out(card_out), .card_idx(card_idx), .card_valid(card_valid),
    .card_ready(card_ready), .busy(busy), .done(done), .dup_err(dup_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  task automatic model(input logic [15:0] s);
    logic [15:0] l;
    int r, j, rej;
    bit found;
    logic [6:0] t;
    l = (s == 16'h0000) ? 16'hACE1 : s;
    for (int k = 0; k < 52; k++) exp_deck[k] = 7'(((k / 4) + 1) * 8 + (k % 4) * 2);
    exp_draws = 0;
    for (int i = 51; i >= 1; i--) begin
      rej = 0; found = 0; j = i; draws_at[i] = 0;
      while (!found) begin
        r = int'(l % 16'd64);
        l = lfsr_next(l);
        draws_at[i]++;
        if (r <= i) begin j = r; found = 1; end
        else begin
          rej++;
          if (rej == MAX_REJ) begin j = i; found = 1; end
        end
      end
      exp_draws += draws_at[i];
      t = exp_deck[i]; exp_deck[i] = exp_deck[j]; exp_deck[j] = t;
    end
  endtask

  task automatic apply_reset;
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b0; seed_load = 1'b0; card_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic kick(input logic [15:0] s, input bit load);
    @(negedge clk);
    seed = s; seed_load = load; start = 1'b1;
    @(posedge clk); #1;
    seed_load = 1'b0; start = 1'b0;
  endtask

  // Runs one stream to DONE and checks it against exp_deck.
  task automatic collect(input bit randrdy, input bit bp, input bit poke, input string tag);
    int cyc, idx_bad, ord_bad, hist_bad;
    int rc [14];
    int sc [4];
    bit held, poked;
    logic [6:0] hold_out;
    cyc = 0; idx_bad = 0; ord_bad = 0; hist_bad = 0; held = 0; poked = 0; got_n = 0;
    hold_out = '0;
    for (int k = 0; k < 14; k++) rc[k] = 0;
    for (int k = 0; k < 4; k++) sc[k] = 0;
    while (!done && cyc < 20000) begin
      @(negedge clk); cyc++;
      start = 1'b0; seed_load = 1'b0;
      if (bp && !held && card_valid && card_idx == 6'd5) begin
        held = 1; hold_out = card_out; card_ready = 1'b0;
        repeat (10) begin
          @(negedge clk); cyc++;
          checks++;
          if (card_out !== hold_out || card_idx !== 6'd5 || card_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s hold: out=%h idx=%0d valid=%b, required out=%h idx=5 valid=1",
                     tag, card_out, card_idx, card_valid, hold_out);
          end
        end
        card_ready = 1'b1;
      end else begin
        card_ready = randrdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (poke && !poked && card_valid && card_idx == 6'd20) begin
        start = 1'b1; seed_load = 1'b1; seed = 16'hBEEF; poked = 1;
      end
      if (card_valid && card_ready) begin
        if (got_n < 52) got[got_n] = card_out;
        if (card_idx !== 6'(got_n)) idx_bad++;
        got_n++;
      end
    end
    card_ready = 1'b0; start = 1'b0; seed_load = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL %s timeout: done=%b after %0d cycles, required 1", tag, done, cyc);
    end
    checks++;
    if (got_n != 52) begin
      errors++; $display("FAIL %s count: got %0d handshakes, required 52", tag, got_n);
    end
    for (int k = 0; k < 52 && k < got_n; k++) begin
      if (got[k] !== exp_deck[k]) ord_bad++;
      if (got[k][6:3] <= 4'd13) rc[got[k][6:3]]++;
      sc[got[k][2:1]]++;
    end
    checks++;
    if (ord_bad != 0) begin
      errors++; $display("FAIL %s order: %0d cards differ from model, required 0", tag, ord_bad);
    end
    checks++;
    if (idx_bad != 0) begin
      errors++; $display("FAIL %s idx: %0d wrong card_idx values, required 0", tag, idx_bad);
    end
    for (int k = 1; k <= 13; k++) if (rc[k] != 4) hist_bad++;
    for (int k = 0; k < 4; k++) if (sc[k] != 13) hist_bad++;
    checks++;
    if (hist_bad != 0) begin
      errors++; $display("FAIL %s histogram: %0d bad rank/suit counts, required 0", tag, hist_bad);
    end
    checks++;
    if (card_valid !== 1'b0 || busy !== 1'b0 || dup_err !== 1'b0) begin
      errors++;
      $display("FAIL %s done_state: valid=%b busy=%b dup_err=%b, required 0 0 0",
               tag, card_valid, busy, dup_err);
    end
    if (bp) begin
      checks++;
      if (!held) begin
        errors++; $display("FAIL %s bp_hit: hold at idx 5 never happened, required 1", tag);
      end
    end
  endtask

  task automatic test_reset;
    apply_reset();
    @(negedge clk);
    checks++;
    if (card_valid !== 1'b0) begin errors++; $display("FAIL reset card_valid: %b, required 0", card_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: %b, required 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset done: %b, required 0", done); end
    checks++;
    if (dup_err !== 1'b0) begin errors++; $display("FAIL reset dup_err: %b, required 0", dup_err); end
    checks++;
    if (card_idx !== 6'd0) begin errors++; $display("FAIL reset card_idx: %0d, required 0", card_idx); end
    checks++;
    if (card_out !== 7'd0) begin errors++; $display("FAIL reset card_out: %h, required 0", card_out); end
  endtask

  task automatic test_basic;
    int lat;
    model(16'h1234);
    kick(16'h1234, 1'b1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic busy: %b after start, required 1", busy); end
    lat = 0;
    while (!card_valid && lat < 5000) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat != 52 + exp_draws + 51) begin
      errors++; $display("FAIL basic latency: %0d cycles, required %0d", lat, 52 + exp_draws + 51);
    end
    collect(1'b0, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_zero_seed;
    logic [6:0] first [52];
    int diff;
    model(16'hACE1);
    kick(16'h0000, 1'b1);
    collect(1'b0, 1'b0, 1'b0, "seed0");
    for (int k = 0; k < 52; k++) first[k] = got[k];
    kick(16'hACE1, 1'b1);
    collect(1'b1, 1'b0, 1'b0, "seedACE1");
    diff = 0;
    for (int k = 0; k < 52; k++) if (first[k] !== got[k]) diff++;
    checks++;
    if (diff != 0) begin
      errors++; $display("FAIL zero_seed_equiv: %0d cards differ, required 0", diff);
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] s;
    s = 16'($urandom);
    model(s);
    kick(s, 1'b1);
    collect(1'b1, 1'b1, 1'b0, "backpressure");
  endtask

  task automatic test_reset_mid;
    int n;
    model(16'h1234);
    n = 52 + 21;
    for (int i = 51; i >= 31; i--) n += draws_at[i];
    kick(16'h1234, 1'b1);
    repeat (n) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || card_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid pre: busy=%b valid=%b, required 1 0", busy, card_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || card_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid async: busy=%b done=%b valid=%b, required 0 0 0",
                         busy, done, card_valid);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    kick(16'h1234, 1'b1);
    collect(1'b0, 1'b0, 1'b0, "reset_mid");
  endtask

  task automatic test_start_ignored;
    model(16'h1234);
    kick(16'h1234, 1'b1);
    collect(1'b1, 1'b0, 1'b1, "start_ignored");
  endtask

  task automatic test_back_to_back;
    logic [15:0] s;
    for (int n = 0; n < 2; n++) begin
      s = 16'($urandom);
      model(s);
      kick(s, 1'b1);
      collect(1'b1, 1'b0, 1'b0, "back_to_back");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_seed();
    test_backpressure();
    test_reset_mid();
    test_start_ignored();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
